// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: shared types and helpers for the UART pixel-packet sequencer.
//   pkt_state_e  - sequencer states (idle, three colour bytes, checksum, pixel hold)
//   HDR_*_DEFAULT - default header byte values
//   pkt_csum()   - 8-bit modular sum of header and colour bytes
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StR,
        StG,
        StB,
        StCsum,
        StOut
    } pkt_state_e;

    localparam logic [7:0] HDR_PIX_DEFAULT = 8'hA5;
    localparam logic [7:0] HDR_SOF_DEFAULT = 8'hA6;

    function automatic logic [7:0] pkt_csum(input logic [7:0] hdr, input logic [7:0] r,
                                            input logic [7:0] g, input logic [7:0] b);
        return hdr + r + g + b;
    endfunction

endpackage

// File: rtl/uart_pkt_timer.sv
// uart_pkt_timer: inter-byte timeout counter.
//   clk, rst - clock, synchronous active-high reset
//   clear    - restart the count (a byte was accepted)
//   enable   - count only while a packet is in progress; held at zero otherwise
//   expire   - high in the cycle the count sits at TIMEOUT_CYC-1 with no clear
module uart_pkt_timer #(
    parameter int unsigned TIMEOUT_CYC = 110000,
    parameter int unsigned TMO_W       = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    assign expire = enable && !clear && (cnt_q == TMO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable || expire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_pkt_ctrl.sv
// uart_pkt_ctrl: frames a UART byte stream into 5-byte pixel packets
// (header, R, G, B, checksum), validates them and hands each good pixel to a
// frame buffer over a valid/ready handshake with an auto-incrementing address.
//   clk, rst              - clock, synchronous active-high reset
//   rx_byte, rx_valid     - byte strobe from the UART receiver
//   pix_data, pix_addr    - {R,G,B} and write address, stable while pix_valid
//   pix_valid, pix_ready  - pixel handshake
//   frame_done            - pulse after the last pixel of a frame transfers
//   busy                  - sequencer not idle
//   err_csum/tmo/ovr      - one-cycle error pulses
//   pkt_ok_cnt/err_cnt    - saturating packet counters
// Optional build macro UART_PKT_STATS_EN: when undefined the counters are not
// built and both counter ports read 16'h0000.
module uart_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter logic [7:0]  HDR_PIX     = HDR_PIX_DEFAULT,
    parameter logic [7:0]  HDR_SOF     = HDR_SOF_DEFAULT,
    parameter int unsigned NUM_PIX     = 76800,
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned TIMEOUT_CYC = 110000,
    parameter int unsigned TMO_W       = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic [23:0]       pix_data,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              frame_done,
    output logic              busy,
    output logic              err_csum,
    output logic              err_tmo,
    output logic              err_ovr,
    output logic [15:0]       pkt_ok_cnt,
    output logic [15:0]       pkt_err_cnt
);

    pkt_state_e        state_q, state_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
    logic              sof_q, sof_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [23:0]       pix_data_q, pix_data_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic              pix_valid_q, pix_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic              err_csum_q, err_csum_d;
    logic              err_tmo_q, err_tmo_d;
    logic              err_ovr_q, err_ovr_d;
    logic              ok_inc, err_inc;
    logic              tmo_en, tmo_expire;

    assign tmo_en = (state_q == StR) || (state_q == StG) || (state_q == StB) ||
                    (state_q == StCsum);

    uart_pkt_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TMO_W       (TMO_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_valid),
        .enable (tmo_en),
        .expire (tmo_expire)
    );

    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        r_d          = r_q;
        g_d          = g_q;
        b_d          = b_q;
        sof_d        = sof_q;
        addr_d       = addr_q;
        pix_data_d   = pix_data_q;
        pix_addr_d   = pix_addr_q;
        pix_valid_d  = pix_valid_q;
        frame_done_d = 1'b0;
        err_csum_d   = 1'b0;
        err_tmo_d    = 1'b0;
        err_ovr_d    = 1'b0;
        ok_inc       = 1'b0;
        err_inc      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Non-header bytes are dropped silently to resync on the stream.
                if (rx_valid && (rx_byte == HDR_PIX || rx_byte == HDR_SOF)) begin
                    state_d = StR;
                    sum_d   = rx_byte;
                    sof_d   = (rx_byte == HDR_SOF);
                end
            end
            StR, StG, StB: begin
                if (rx_valid) begin
                    sum_d = sum_q + rx_byte;
                    if (state_q == StR) begin
                        r_d     = rx_byte;
                        state_d = StG;
                    end else if (state_q == StG) begin
                        g_d     = rx_byte;
                        state_d = StB;
                    end else begin
                        b_d     = rx_byte;
                        state_d = StCsum;
                    end
                end else if (tmo_expire) begin
                    state_d   = StIdle;
                    err_tmo_d = 1'b1;
                    err_inc   = 1'b1;
                end
            end
            StCsum: begin
                if (rx_valid) begin
                    if (rx_byte == sum_q) begin
                        state_d     = StOut;
                        pix_valid_d = 1'b1;
                        pix_data_d  = {r_q, g_q, b_q};
                        // The address only moves once the pixel is accepted, so a
                        // failed SOF packet leaves it untouched.
                        pix_addr_d  = sof_q ? '0 : addr_q;
                        ok_inc      = 1'b1;
                    end else begin
                        state_d    = StIdle;
                        err_csum_d = 1'b1;
                        err_inc    = 1'b1;
                    end
                end else if (tmo_expire) begin
                    state_d   = StIdle;
                    err_tmo_d = 1'b1;
                    err_inc   = 1'b1;
                end
            end
            StOut: begin
                // No buffering while a pixel is held: any incoming byte is lost.
                if (rx_valid) begin
                    err_ovr_d = 1'b1;
                end
                if (pix_ready) begin
                    state_d     = StIdle;
                    pix_valid_d = 1'b0;
                    if (pix_addr_q == ADDR_W'(NUM_PIX - 1)) begin
                        addr_d       = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        addr_d = pix_addr_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sum_q        <= '0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            sof_q        <= 1'b0;
            addr_q       <= '0;
            pix_data_q   <= '0;
            pix_addr_q   <= '0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            err_csum_q   <= 1'b0;
            err_tmo_q    <= 1'b0;
            err_ovr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            sof_q        <= sof_d;
            addr_q       <= addr_d;
            pix_data_q   <= pix_data_d;
            pix_addr_q   <= pix_addr_d;
            pix_valid_q  <= pix_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            err_csum_q   <= err_csum_d;
            err_tmo_q    <= err_tmo_d;
            err_ovr_q    <= err_ovr_d;
        end
    end

    assign pix_data   = pix_data_q;
    assign pix_addr   = pix_addr_q;
    assign pix_valid  = pix_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign err_csum   = err_csum_q;
    assign err_tmo    = err_tmo_q;
    assign err_ovr    = err_ovr_q;

`ifdef UART_PKT_STATS_EN
    logic [15:0] ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;

    always_comb begin
        ok_cnt_d  = ok_cnt_q;
        err_cnt_d = err_cnt_q;
        if (ok_inc && ok_cnt_q != 16'hFFFF) begin
            ok_cnt_d = ok_cnt_q + 16'd1;
        end
        if (err_inc && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ok_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            ok_cnt_q  <= ok_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pkt_ok_cnt  = ok_cnt_q;
    assign pkt_err_cnt = err_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = ok_inc ^ err_inc;
    assign pkt_ok_cnt   = 16'h0000;
    assign pkt_err_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// tb_uart_pkt_ctrl: self-checking bench for uart_pkt_ctrl (small NUM_PIX and
// TIMEOUT_CYC so frame wrap and timeouts are reached quickly).
module tb_uart_pkt_ctrl;
    import uart_pkt_pkg::*;

    localparam int unsigned NPIX = 4;
    localparam int unsigned TMO  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [23:0] pix_data;
    logic [16:0] pix_addr;
    logic        pix_valid;
    logic        pix_ready;
    logic        frame_done;
    logic        busy;
    logic        err_csum;
    logic        err_tmo;
    logic        err_ovr;
    logic [15:0] pkt_ok_cnt;
    logic [15:0] pkt_err_cnt;

    always #5 clk = ~clk;

    uart_pkt_ctrl #(
        .NUM_PIX     (NPIX),
        .ADDR_W      (17),
        .TIMEOUT_CYC (TMO),
        .TMO_W       (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .pix_data    (pix_data),
        .pix_addr    (pix_addr),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .frame_done  (frame_done),
        .busy        (busy),
        .err_csum    (err_csum),
        .err_tmo     (err_tmo),
        .err_ovr     (err_ovr),
        .pkt_ok_cnt  (pkt_ok_cnt),
        .pkt_err_cnt (pkt_err_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: bytes of the packet being collected, idle-cycle gap since
    // the last byte, and the pixel currently offered to the frame buffer.
    logic [7:0]  pkt[$];
    int          gap;
    bit          m_hold;
    logic [23:0] m_pdata;
    int          m_paddr;
    int          m_addr;
    int          m_ok;
    int          m_err;
    bit          e_csum, e_tmo, e_ovr, e_done;

    task automatic model_reset();
        pkt.delete();
        gap = 0; m_hold = 0; m_pdata = '0; m_paddr = 0; m_addr = 0;
        m_ok = 0; m_err = 0;
        e_csum = 0; e_tmo = 0; e_ovr = 0; e_done = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] b, input bit rdy);
        e_csum = 0; e_tmo = 0; e_ovr = 0; e_done = 0;
        if (m_hold) begin
            if (v) e_ovr = 1;
            if (rdy) begin
                m_hold = 0;
                if (m_paddr == NPIX - 1) begin
                    m_addr = 0;
                    e_done = 1;
                end else begin
                    m_addr = m_paddr + 1;
                end
            end
        end else if (pkt.size() == 0) begin
            if (v && (b == 8'hA5 || b == 8'hA6)) begin
                pkt.push_back(b);
                gap = 0;
            end
        end else if (v) begin
            gap = 0;
            if (pkt.size() == 4) begin
                if (b == pkt_csum(pkt[0], pkt[1], pkt[2], pkt[3])) begin
                    m_hold  = 1;
                    m_pdata = {pkt[1], pkt[2], pkt[3]};
                    m_paddr = (pkt[0] == 8'hA6) ? 0 : m_addr;
                    if (m_ok < 65535) m_ok++;
                end else begin
                    e_csum = 1;
                    if (m_err < 65535) m_err++;
                end
                pkt.delete();
            end else begin
                pkt.push_back(b);
            end
        end else begin
            gap++;
            if (gap == TMO) begin
                e_tmo = 1;
                if (m_err < 65535) m_err++;
                pkt.delete();
            end
        end
    endtask

    task automatic compare_model();
        chk("pix_valid", pix_valid, m_hold);
        chk("busy", busy, (m_hold || pkt.size() > 0));
        chk("err_csum", err_csum, e_csum);
        chk("err_tmo", err_tmo, e_tmo);
        chk("err_ovr", err_ovr, e_ovr);
        chk("frame_done", frame_done, e_done);
        if (m_hold) begin
            chk("pix_data", pix_data, m_pdata);
            chk("pix_addr", pix_addr, m_paddr);
        end
`ifdef UART_PKT_STATS_EN
        chk("pkt_ok_cnt", pkt_ok_cnt, m_ok);
        chk("pkt_err_cnt", pkt_err_cnt, m_err);
`else
        chk("pkt_ok_cnt", pkt_ok_cnt, 0);
        chk("pkt_err_cnt", pkt_err_cnt, 0);
`endif
    endtask

    // One clock: drive inputs, step the model with the pre-edge inputs, compare #1 after.
    task automatic cycle(input bit v, input logic [7:0] b, input bit rdy);
        rx_valid  = v;
        rx_byte   = b;
        pix_ready = rdy;
        @(posedge clk);
        model_step(v, b, rdy);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_byte = '0; pix_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_pix_addr", pix_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {err_csum, err_tmo, err_ovr, frame_done}, 0);
        chk("rst_cnts", {pkt_ok_cnt, pkt_err_cnt}, 0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send_pkt(input logic [7:0] h, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input bit good, input bit rdy);
        logic [7:0] cs;
        cs = pkt_csum(h, r, g, b) ^ (good ? 8'h00 : 8'h01);
        cycle(1, h, rdy); cycle(1, r, rdy); cycle(1, g, rdy); cycle(1, b, rdy);
        cycle(1, cs, rdy);
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  b;
        logic        rdy;
        logic        e_valid;
        logic [23:0] e_data;
        logic [16:0] e_addr;
        logic        e_busy;
        logic        e_csum;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [7:0] b, logic ev, logic [23:0] ed,
                                logic [16:0] ea, logic eb, logic ec);
        vec_t t;
        t.v = v; t.b = b; t.rdy = 1'b1; t.e_valid = ev; t.e_data = ed; t.e_addr = ea;
        t.e_busy = eb; t.e_csum = ec;
        return t;
    endfunction

    initial begin
        logic [23:0] held;
        int          kind;

        // Packet, second packet, bad checksum, SOF packet, packet after SOF.
        tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h10, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h20, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h30, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h05, 1, 24'h102030, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h11, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h22, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h33, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h0B, 1, 24'h112233, 1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h10, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h20, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h30, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h06, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'hA6, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h01, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h02, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h03, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'hAC, 1, 24'h010203, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h01, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h01, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h01, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'hA8, 1, 24'h010101, 1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0));

        do_reset();

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].b, tbl[i].rdy);
            chk("tbl_valid", pix_valid, tbl[i].e_valid);
            chk("tbl_busy", busy, tbl[i].e_busy);
            chk("tbl_err_csum", err_csum, tbl[i].e_csum);
            if (tbl[i].e_valid) begin
                chk("tbl_data", pix_data, tbl[i].e_data);
                chk("tbl_addr", pix_addr, tbl[i].e_addr);
            end
        end

        // Timeout: header + R then silence; a byte exactly at the limit would win.
        cycle(1, 8'hA5, 1);
        cycle(1, 8'h10, 1);
        for (int k = 1; k <= TMO; k++) cycle(0, 8'h00, 1);
        chk("tmo_pulse", err_tmo, 1);
        chk("tmo_busy", busy, 0);
        cycle(1, 8'h3C, 1);
        chk("tmo_once", err_tmo, 0);
        chk("resync_busy", busy, 0);
        send_pkt(8'hA5, 8'h44, 8'h55, 8'h66, 1, 1);
        chk("post_tmo_valid", pix_valid, 1);
        chk("post_tmo_data", pix_data, 24'h445566);
        cycle(0, 8'h00, 1);

        // Byte arriving on the last allowed cycle is accepted.
        cycle(1, 8'hA5, 1);
        for (int k = 1; k < TMO; k++) cycle(0, 8'h00, 1);
        cycle(1, 8'h77, 1);
        chk("tmo_edge_no_err", err_tmo, 0);
        chk("tmo_edge_busy", busy, 1);
        cycle(1, 8'h01, 1); cycle(1, 8'h02, 1);
        cycle(1, pkt_csum(8'hA5, 8'h77, 8'h01, 8'h02), 0);
        chk("tmo_edge_valid", pix_valid, 1);

        // Overrun while holding, then a single transfer.
        held = pix_data;
        cycle(1, 8'h55, 0);
        chk("ovr_pulse", err_ovr, 1);
        chk("ovr_held", pix_data, held);
        chk("ovr_valid", pix_valid, 1);
        cycle(0, 8'h00, 0);
        chk("ovr_once", err_ovr, 0);
        cycle(0, 8'h00, 1);
        chk("xfer_valid", pix_valid, 0);
        cycle(0, 8'h00, 1);
        chk("xfer_single", pix_valid, 0);

        // Frame wrap: SOF at 0, then 1..3; frame_done after the 4th transfer.
        send_pkt(8'hA6, 8'h00, 8'h00, 8'h01, 1, 0);
        cycle(0, 8'h00, 1);
        for (int p = 1; p < 4; p++) begin
            send_pkt(8'hA5, 8'(p), 8'(p), 8'(p), 1, 0);
            chk("wrap_addr", pix_addr, p);
            cycle(0, 8'h00, 1);
        end
        chk("frame_done", frame_done, 1);
        cycle(0, 8'h00, 1);
        chk("frame_done_once", frame_done, 0);
        send_pkt(8'hA5, 8'h09, 8'h09, 8'h09, 1, 0);
        chk("wrap_to_zero", pix_addr, 0);

        // Reset while holding a pixel.
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                cycle(1, 8'($urandom), ($urandom_range(0, 3) != 0));
            end else if (kind == 8) begin
                cycle(1, 8'hA5, 1);
                cycle(1, 8'($urandom), 1);
                for (int k = 0; k < TMO + 2; k++) cycle(0, 8'h00, ($urandom_range(0, 3) != 0));
            end else begin
                logic [7:0] h, r, g, b, cs;
                h  = (kind == 9) ? 8'hA6 : 8'hA5;
                r  = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
                cs = pkt_csum(h, r, g, b) ^ ((kind == 7) ? 8'h80 : 8'h00);
                cycle(1, h, ($urandom_range(0, 3) != 0));
                cycle(1, r, ($urandom_range(0, 3) != 0));
                cycle(1, g, ($urandom_range(0, 3) != 0));
                cycle(1, b, ($urandom_range(0, 3) != 0));
                cycle(1, cs, ($urandom_range(0, 3) != 0));
            end
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                cycle(0, 8'h00, ($urandom_range(0, 3) != 0));
            end
        end
        for (int k = 0; k < 4; k++) cycle(0, 8'h00, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
